decode_issue: RTL
=================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port instValid_in, input, 1, an instruction word is offered by fetch.
REQ-004 SHALL have ports inst_in (input, 32, instruction word) and pc_in (input, 32, its address).
REQ-005 SHALL have port ready_out, output, 1, accepts the offered instruction this cycle.
REQ-006 SHALL have ports rs1Idx_out and rs2Idx_out, output, 5 each, register-file read addresses (combinational from inst_in).
REQ-007 SHALL have ports rs1RegData_in and rs2RegData_in, input, 32 each, register-file read data (same cycle).
REQ-008 SHALL have ports exRdE_in (1), exRdIdx_in (5) and exRdData_in (32), inputs, forwarding path from the execute result.
REQ-009 SHALL have ports flush_in (input, 1, squash) and exReady_in (input, 1, execute can take an issued op).
REQ-010 SHALL have outputs valid_out (1), instIdx_out and instType_out (shared widths), rs1Data_out and rs2Data_out (32 each), rdE_out (1), rdIdx_out (5), illegal_out (1).

Function
REQ-011 SHALL decode LUI, AUIPC, OP-IMM (ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI) and OP (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND) into the shared instIdx/instType codes.
REQ-012 SHALL form operands as: LUI rs1=immU, rs2=0; AUIPC rs1=pc_in, rs2=immU; OP-IMM rs2=sign-extended imm12, shifts rs2=zero-extended shamt[4:0]; OP rs2=register value, with shifts masked to bits [4:0].
REQ-013 SHALL take the register value from exRdData_in when exRdE_in=1, exRdIdx_in equals the source index and the index is nonzero; otherwise from rsNRegData_in; x0 always reads 0.
REQ-014 SHALL set rdE_out=1 only for decoded instructions with rd!=0; rdIdx_out=rd field.
REQ-015 SHALL treat any other opcode/funct combination as a NOP (instIdx=NOP code, rdE=0) and pulse illegal_out for exactly the cycle that NOP is presented with valid_out=1.
REQ-016 SHALL drive ready_out = !valid_out || exReady_in (combinational).
REQ-017 SHALL, on a rising edge with instValid_in && ready_out, register all decoded fields and set valid_out=1 the next cycle (latency 1).
REQ-018 SHALL, when valid_out && !exReady_in, hold every output stable (no field may change while stalled).
REQ-019 SHALL, when exReady_in=1 and no new instruction is accepted, clear valid_out the next cycle.
REQ-020 SHALL, on flush_in=1, clear valid_out, rdE_out and illegal_out the next cycle and ignore any simultaneous accept; flush has priority over stall and accept.

Reset
REQ-021 SHALL, while rst_in=1, force valid_out=0, rdE_out=0, illegal_out=0, rdIdx_out=0, rs1Data_out=rs2Data_out=0, instIdx_out=NOP code, instType_out=0, regardless of clock.
REQ-022 SHALL, on reset asserted mid-stall, discard the held instruction and, after release, accept a new instruction on the first edge.

Structure
REQ-023 SHALL take opcode, funct3/funct7, instIdx and instType codes, NOP code, ZERO32 and width ranges from the shared defines header; no local redefinition.
REQ-024 SHALL place decode (fields, immediates, codes) in one combinational sub-module named inst_decoder; forwarding muxes and the issue register stay in decode_issue.

Verification
REQ-025 SHALL check 0xFFF00293 (ADDI x5,x0,-1), exReady=1 -> next cycle valid=1, ADD code, Arith type, rs1=0, rs2=0xFFFFFFFF, rdE=1, rdIdx=5.
REQ-026 SHALL check 0x123450B7 (LUI x1) then AUIPC at pc=0x100 with imm 0x1 -> rs1=0x12345000/rs2=0; then rs1=0x100/rs2=0x1000.
REQ-027 SHALL check 0x402081B3 (SUB x3,x1,x2) with reg x1=5, x2=7 and exRdE=1, exRdIdx=2, exRdData=9 -> rs1=5, rs2=9.
REQ-028 SHALL check 0x40325213 (SRAI x4,x4,3) with exReady=0 for 3 cycles -> outputs frozen, ready_out=0; exReady=1 -> next instruction accepted.
REQ-029 SHALL check opcode 0x7F word -> NOP, rdE=0, illegal_out=1 one cycle; flush_in with instValid_in=1 -> valid_out=0 next cycle.
REQ-030 SHALL check rst_in pulse mid-stall -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared opcodes, funct codes, instIdx/instType codes and decode types
package decode_issue_pkg;
  localparam int XLEN = 32;
  localparam int RIDX_W = 5;
  localparam int IDX_W = 4;
  localparam int TYPE_W = 3;
  localparam logic [XLEN-1:0] ZERO32 = '0;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SR = 3'd5;
  localparam logic [2:0] F3_OR = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  typedef enum logic [IDX_W-1:0] {
    IDX_NOP, IDX_ADD, IDX_SUB, IDX_SLL, IDX_SLT, IDX_SLTU,
    IDX_XOR, IDX_SRL, IDX_SRA, IDX_OR, IDX_AND
  } inst_idx_e;
  typedef enum logic [TYPE_W-1:0] {
    TYPE_NONE, TYPE_ARITH, TYPE_LOGIC, TYPE_SHIFT, TYPE_CMP
  } inst_type_e;
  typedef enum logic [1:0] {A_ZERO, A_REG, A_PC, A_IMM} opa_sel_e;
  typedef enum logic [1:0] {B_ZERO, B_REG, B_REG_SH, B_IMM} opb_sel_e;
  typedef struct packed {
    logic [RIDX_W-1:0] rs1_idx;
    logic [RIDX_W-1:0] rs2_idx;
    logic [RIDX_W-1:0] rd_idx;
    inst_idx_e         idx;
    inst_type_e        typ;
    opa_sel_e          a_sel;
    opb_sel_e          b_sel;
    logic [XLEN-1:0]   imm;
    logic              rd_e;
    logic              ill;
  } dec_t;
  function automatic inst_idx_e alu_idx(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? IDX_SUB : IDX_ADD;
      F3_SLL:  return IDX_SLL;
      F3_SLT:  return IDX_SLT;
      F3_SLTU: return IDX_SLTU;
      F3_XOR:  return IDX_XOR;
      F3_SR:   return alt ? IDX_SRA : IDX_SRL;
      F3_OR:   return IDX_OR;
      default: return IDX_AND;
    endcase
  endfunction
  function automatic inst_type_e type_of(input inst_idx_e i);
    return (i == IDX_ADD || i == IDX_SUB) ? TYPE_ARITH :
           (i == IDX_SLL || i == IDX_SRL || i == IDX_SRA) ? TYPE_SHIFT :
           (i == IDX_SLT || i == IDX_SLTU) ? TYPE_CMP :
           (i == IDX_XOR || i == IDX_OR || i == IDX_AND) ? TYPE_LOGIC : TYPE_NONE;
  endfunction
endpackage

// File: rtl/decode_issue_inst_decoder.sv
// inst_decoder: combinational field, immediate and instIdx/instType decode of one RV32I word
module inst_decoder
  import decode_issue_pkg::*;
(
  input  logic [XLEN-1:0] inst_in,
  output dec_t            dec_out
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       sh, alt;
  assign opc = inst_in[6:0];
  assign f3 = inst_in[14:12];
  assign f7 = inst_in[31:25];
  assign sh = f3 == F3_SLL || f3 == F3_SR;
  assign alt = f7 == F7_ALT;
  always_comb begin
    dec_out = '0;
    dec_out.rs1_idx = inst_in[19:15];
    dec_out.rs2_idx = inst_in[24:20];
    dec_out.rd_idx = inst_in[11:7];
    dec_out.idx = IDX_NOP;
    dec_out.a_sel = A_ZERO;
    dec_out.b_sel = B_ZERO;
    dec_out.imm = ZERO32;
    dec_out.ill = 1'b1;
    case (opc)
      OPC_LUI: begin
        dec_out.idx = IDX_ADD;
        dec_out.ill = 1'b0;
        dec_out.a_sel = A_IMM;
        dec_out.imm = {inst_in[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec_out.idx = IDX_ADD;
        dec_out.ill = 1'b0;
        dec_out.a_sel = A_PC;
        dec_out.b_sel = B_IMM;
        dec_out.imm = {inst_in[31:12], 12'b0};
      end
      OPC_OPIMM: if (!sh || f7 == F7_ZERO || (f3 == F3_SR && alt)) begin
        dec_out.idx = alu_idx(f3, f3 == F3_SR && alt);
        dec_out.ill = 1'b0;
        dec_out.a_sel = A_REG;
        dec_out.b_sel = B_IMM;
        dec_out.imm = sh ? {27'b0, inst_in[24:20]} : {{20{inst_in[31]}}, inst_in[31:20]};
      end
      OPC_OP: if (f7 == F7_ZERO || (alt && (f3 == F3_ADD || f3 == F3_SR))) begin
        dec_out.idx = alu_idx(f3, alt);
        dec_out.ill = 1'b0;
        dec_out.a_sel = A_REG;
        dec_out.b_sel = sh ? B_REG_SH : B_REG;
      end
      default: ;
    endcase
    dec_out.typ = type_of(dec_out.idx);
    dec_out.rd_e = !dec_out.ill && dec_out.rd_idx != '0;
  end
endmodule

// File: rtl/decode_issue.sv
// decode_issue: decodes one instruction, forwards operands and holds it in a stallable issue register
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              instValid_in,
  input  logic [XLEN-1:0]   inst_in,
  input  logic [XLEN-1:0]   pc_in,
  output logic              ready_out,
  output logic [RIDX_W-1:0] rs1Idx_out,
  output logic [RIDX_W-1:0] rs2Idx_out,
  input  logic [XLEN-1:0]   rs1RegData_in,
  input  logic [XLEN-1:0]   rs2RegData_in,
  input  logic              exRdE_in,
  input  logic [RIDX_W-1:0] exRdIdx_in,
  input  logic [XLEN-1:0]   exRdData_in,
  input  logic              flush_in,
  input  logic              exReady_in,
  output logic              valid_out,
  output logic [IDX_W-1:0]  instIdx_out,
  output logic [TYPE_W-1:0] instType_out,
  output logic [XLEN-1:0]   rs1Data_out,
  output logic [XLEN-1:0]   rs2Data_out,
  output logic              rdE_out,
  output logic [RIDX_W-1:0] rdIdx_out,
  output logic              illegal_out
);
  typedef struct packed {
    inst_idx_e         idx;
    inst_type_e        typ;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic              rd_e;
    logic [RIDX_W-1:0] rd_idx;
    logic              ill;
  } iss_t;
  localparam iss_t ISS_RST = '{idx: IDX_NOP, typ: TYPE_NONE, rs1: ZERO32, rs2: ZERO32,
                               rd_e: 1'b0, rd_idx: '0, ill: 1'b0};
  dec_t            dec;
  iss_t            iss_d, iss_q;
  logic            valid_d, valid_q, accept;
  logic [XLEN-1:0] rs1_v, rs2_v;
  inst_decoder u_dec (.inst_in(inst_in), .dec_out(dec));
  function automatic logic [XLEN-1:0] fwd(input logic [RIDX_W-1:0] idx, input logic [XLEN-1:0] rf);
    return (idx == '0) ? ZERO32 : (exRdE_in && exRdIdx_in == idx) ? exRdData_in : rf;
  endfunction
  always_comb begin
    rs1_v = fwd(dec.rs1_idx, rs1RegData_in);
    rs2_v = fwd(dec.rs2_idx, rs2RegData_in);
    ready_out = !valid_q || exReady_in;
    accept = instValid_in && ready_out && !flush_in;
    valid_d = !flush_in && (accept || (valid_q && !exReady_in));
    iss_d = iss_q;
    if (accept) begin
      iss_d.idx = dec.idx;
      iss_d.typ = dec.typ;
      iss_d.rs1 = dec.a_sel == A_REG ? rs1_v : dec.a_sel == A_PC ? pc_in :
                  dec.a_sel == A_IMM ? dec.imm : ZERO32;
      iss_d.rs2 = dec.b_sel == B_REG ? rs2_v : dec.b_sel == B_REG_SH ? {27'b0, rs2_v[4:0]} :
                  dec.b_sel == B_IMM ? dec.imm : ZERO32;
      iss_d.rd_e = dec.rd_e;
      iss_d.rd_idx = dec.rd_idx;
      iss_d.ill = dec.ill;
    end
    // side-effect flags never outlive the slot they belong to
    if (!valid_d) begin
      iss_d.rd_e = 1'b0;
      iss_d.ill = 1'b0;
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      iss_q <= ISS_RST;
    end else begin
      valid_q <= valid_d;
      iss_q <= iss_d;
    end
  end
  assign rs1Idx_out = dec.rs1_idx;
  assign rs2Idx_out = dec.rs2_idx;
  assign valid_out = valid_q;
  assign instIdx_out = iss_q.idx;
  assign instType_out = iss_q.typ;
  assign rs1Data_out = iss_q.rs1;
  assign rs2Data_out = iss_q.rs2;
  assign rdE_out = iss_q.rd_e;
  assign rdIdx_out = iss_q.rd_idx;
  assign illegal_out = iss_q.ill;
endmodule
